// File: rtl/launch_pkg.sv
// Shared types and constants for the program launcher.
package launch_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        CORE_RST = 3'd2,
        RUN      = 3'd3,
        DRAIN    = 3'd4,
        FINISH   = 3'd5
    } state_t;

    localparam int CORE_RST_CYCLES = 2;
    localparam int RST_CNT_W       = (CORE_RST_CYCLES > 2) ? $clog2(CORE_RST_CYCLES) : 1;

    // Width able to hold a window length; a zero-length window still gets one bit.
    function automatic int cnt_width(input int len);
        return (len < 2) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/win_counter.sv
// Window index counter: remaining-words down-counter with terminal compare,
// plus an up-counting index added to the window base address.
module win_counter
    import launch_pkg::*;
#(
    parameter int AW   = 8,
    parameter int BASE = 0,
    parameter int LEN  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int CNT_W = cnt_width(LEN);

    logic [CNT_W-1:0] remain;
    logic [AW-1:0]    index;

    always_ff @(posedge clk) begin
        if (reset) begin
            remain <= '0;
            index  <= '0;
        end else if (load) begin
            remain <= CNT_W'(LEN);
            index  <= '0;
        end else if (inc && (remain != '0)) begin
            remain <= remain - 1'b1;
            index  <= index + 1'b1;
        end
    end

    // Index wraps naturally modulo 2^AW.
    assign addr = AW'(BASE) + index;
    assign last = (remain == CNT_W'(1));

endmodule

// File: rtl/prog_launcher.sv
// Host-side run initiator: preload memory, reset/release core, await done, drain results.
// Optional running XOR of drained words when LAUNCH_CHECKSUM_EN is defined.
//
// state    | meaning
// IDLE     | waiting for start after reset
// LOAD     | accepting preload words into data memory
// CORE_RST | core held in reset for CORE_RST_CYCLES
// RUN      | core owns memory, counting cycles until done or timeout
// DRAIN    | streaming result window out
// FINISH   | run complete, status held until next start
module prog_launcher
    import launch_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_LEN   = 32,
    parameter int TIMEOUT   = 4096,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          mem_own,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] run_cycles,
    output logic [DW-1:0] checksum
);

    state_t state, state_nxt;

    logic                 start_go;
    logic                 ld_fire;
    logic                 res_fire;
    logic                 ld_last;
    logic                 res_last;
    logic                 rst_done;
    logic                 timeout_hit;
    logic [AW-1:0]        ld_addr;
    logic [AW-1:0]        res_addr;
    logic [RST_CNT_W-1:0] rst_cnt;
    logic [CW:0]          run_cycles_inc;

    assign start_go = start && ((state == IDLE) || (state == FINISH));
    // Handshakes are suppressed while reset is high so an in-flight word is dropped.
    assign ld_fire  = (state == LOAD)  && ld_valid  && !reset;
    assign res_fire = (state == DRAIN) && res_ready && !reset;

    win_counter #(
        .AW   (AW),
        .BASE (LOAD_BASE),
        .LEN  (LOAD_LEN)
    ) u_ld_win (
        .clk   (clk),
        .reset (reset),
        .load  (start_go),
        .inc   (ld_fire),
        .addr  (ld_addr),
        .last  (ld_last)
    );

    win_counter #(
        .AW   (AW),
        .BASE (RES_BASE),
        .LEN  (RES_LEN)
    ) u_res_win (
        .clk   (clk),
        .reset (reset),
        .load  (start_go),
        .inc   (res_fire),
        .addr  (res_addr),
        .last  (res_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FINISH: begin
                if (start) begin
                    state_nxt = (LOAD_LEN == 0) ? CORE_RST : LOAD;
                end
            end
            LOAD: begin
                if (ld_fire && ld_last) begin
                    state_nxt = CORE_RST;
                end
            end
            CORE_RST: begin
                if (rst_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (core_done) begin
                    state_nxt = (RES_LEN == 0) ? FINISH : DRAIN;
                end else if (timeout_hit) begin
                    state_nxt = FINISH;
                end
            end
            DRAIN: begin
                if (res_fire && res_last) begin
                    state_nxt = FINISH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_ready    = 1'b0;
        core_reset  = 1'b1;
        core_req    = 1'b0;
        mem_own     = 1'b1;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        res_valid   = 1'b0;
        res_data    = '0;
        busy        = 1'b1;
        finished    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                ld_ready = !reset;
                mem_addr = ld_addr;
                if (ld_fire) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = ld_data;
                end
            end
            RUN: begin
                core_reset = 1'b0;
                core_req   = 1'b1;
                mem_own    = 1'b0;
            end
            DRAIN: begin
                mem_addr  = res_addr;
                res_valid = !reset;
                res_data  = mem_rd_data;
            end
            FINISH: begin
                busy     = 1'b0;
                finished = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Reloaded whenever outside CORE_RST so every entry gets the full hold time.
    always_ff @(posedge clk) begin
        if (reset || (state != CORE_RST)) begin
            rst_cnt <= RST_CNT_W'(CORE_RST_CYCLES - 1);
        end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
        end
    end

    assign rst_done = (rst_cnt == '0);

    assign run_cycles_inc = {1'b0, run_cycles} + 1'b1;
    assign timeout_hit    = (run_cycles_inc >= (CW + 1)'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cycles <= '0;
            timed_out  <= 1'b0;
        end else if (start_go) begin
            run_cycles <= '0;
            timed_out  <= 1'b0;
        end else if (state == RUN) begin
            if (run_cycles != '1) begin
                run_cycles <= run_cycles_inc[CW-1:0];
            end
            if (!core_done && timeout_hit) begin
                timed_out <= 1'b1;
            end
        end
    end

`ifdef LAUNCH_CHECKSUM_EN
    logic [DW-1:0] csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
        end else if (start_go) begin
            csum <= '0;
        end else if (res_fire) begin
            csum <= csum ^ mem_rd_data;
        end
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher: table of run scenarios plus scoreboards
// for memory writes and drained result words.
module tb_prog_launcher;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int LOAD_LEN = 4;
    localparam int RES_BASE = 64;
    localparam int RES_LEN  = 32;
    localparam int TIMEOUT  = 16;
    localparam int CW       = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          core_reset;
    logic          core_req;
    logic          core_done;
    logic          mem_own;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] run_cycles;
    logic [DW-1:0] checksum;

    prog_launcher #(
        .AW        (AW),
        .DW        (DW),
        .LOAD_BASE (0),
        .LOAD_LEN  (LOAD_LEN),
        .RES_BASE  (RES_BASE),
        .RES_LEN   (RES_LEN),
        .TIMEOUT   (TIMEOUT),
        .CW        (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .core_reset  (core_reset),
        .core_req    (core_req),
        .core_done   (core_done),
        .mem_own     (mem_own),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .busy        (busy),
        .finished    (finished),
        .timed_out   (timed_out),
        .run_cycles  (run_cycles),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    assign mem_rd_data = mem[mem_addr];

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] res_q[$];
    wr_t        e_wr;
    int         res_hs;
    int         res_vld_cyc;
    logic       stalled = 1'b0;
    logic [7:0] stall_data;

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (mem_own && mem_wr_en) begin
            if (wr_q.size() == 0) begin
                chk("spurious_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                e_wr = wr_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e_wr.addr));
                chk("wr_data", 32'(mem_wr_data), 32'(e_wr.data));
            end
            mem[mem_addr] = mem_wr_data;
        end
        if (res_valid) begin
            res_vld_cyc++;
            if (stalled) chk("res_stable", 32'(res_data), 32'(stall_data));
            if (res_ready) begin
                res_hs++;
                if (res_q.size() == 0) chk("spurious_res", 32'(res_data), 32'hFFFF_FFFF);
                else chk("res_data", 32'(res_data), 32'(res_q.pop_front()));
                stalled = 1'b0;
            end else begin
                stalled    = 1'b1;
                stall_data = res_data;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        core_done = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_run(input int done_at, input int stall, input int mem_mode,
                          input logic [15:0] exp_cyc, input logic exp_to, input int seed);
        logic [7:0] w [4];
        logic [7:0] csum;
        logic [7:0] exp_csum;
        logic [3:0] pat;
        wr_t        e;
        int         k;
        int         c;
        pat = (stall != 0) ? 4'b1001 : 4'b1111;
        for (int i = 0; i < LOAD_LEN; i++) w[i] = 8'((i + 1) * 17) ^ 8'(seed);
        for (int i = 0; i < RES_LEN; i++) begin
            if (mem_mode == 1) mem[RES_BASE + i] = (i == 0) ? 8'h0F : (i == 1) ? 8'hF0 : (i == 2) ? 8'hFF : 8'h00;
            else mem[RES_BASE + i] = 8'($urandom);
        end
        wr_q.delete();
        res_q.delete();
        csum = '0;
        if (done_at > 0 && done_at <= TIMEOUT) begin
            for (int i = 0; i < RES_LEN; i++) begin
                res_q.push_back(mem[RES_BASE + i]);
                csum ^= mem[RES_BASE + i];
            end
        end
        for (int i = 0; i < LOAD_LEN; i++) begin
            e.addr = 8'(i);
            e.data = w[i];
            wr_q.push_back(e);
        end
        res_hs      = 0;
        res_vld_cyc = 0;

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clr_timed_out", 32'(timed_out), 32'd0);
        chk("start_clr_run_cycles", 32'(run_cycles), 32'd0);
        chk("load_busy", 32'(busy), 32'd1);
        for (int i = 0; i < LOAD_LEN; i++) begin
            ld_valid = 1'b1;
            ld_data  = w[i];
            chk("ld_ready", 32'(ld_ready), 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        chk("load_all_written", 32'(wr_q.size()), 32'd0);
        chk("crst1_core_reset", 32'(core_reset), 32'd1);
        chk("crst1_core_req", 32'(core_req), 32'd0);
        tick();
        chk("crst2_core_reset", 32'(core_reset), 32'd1);
        tick();
        chk("run_core_req", 32'(core_req), 32'd1);
        chk("run_core_reset", 32'(core_reset), 32'd0);
        chk("run_mem_own", 32'(mem_own), 32'd0);

        k = 1;
        while (core_req && k <= 40) begin
            core_done = (k == done_at);
            start     = (k == 2);
            tick();
            k++;
        end
        core_done = 1'b0;
        start     = 1'b0;
        chk("run_left_in_bound", 32'(core_req), 32'd0);

        c = 0;
        while (!finished && c < 400) begin
            res_ready = pat[c[1:0]];
            tick();
            c++;
        end
        res_ready = 1'b0;
        chk("finished", 32'(finished), 32'd1);
        chk("finish_busy", 32'(busy), 32'd0);
        chk("run_cycles", 32'(run_cycles), 32'(exp_cyc));
        chk("timed_out", 32'(timed_out), 32'(exp_to));
        chk("res_all_drained", 32'(res_q.size()), 32'd0);
        chk("res_handshakes", 32'(res_hs), exp_to ? 32'd0 : 32'(RES_LEN));
        if (exp_to) chk("no_res_valid", 32'(res_vld_cyc), 32'd0);
`ifdef LAUNCH_CHECKSUM_EN
        exp_csum = csum;
`else
        exp_csum = 8'h00;
`endif
        chk("checksum", 32'(checksum), 32'(exp_csum));
        if (mem_mode == 1) chk("checksum_pattern", 32'(checksum), 32'd0);
    endtask

    typedef struct {
        int          done_at;
        int          stall;
        int          mem_mode;
        logic [15:0] exp_cyc;
        logic        exp_to;
    } vec_t;

    vec_t vecs [5];

    initial begin
        wr_t e;
        vecs[0] = '{10, 0, 0, 16'd10, 1'b0};
        vecs[1] = '{1,  1, 0, 16'd1,  1'b0};
        vecs[2] = '{0,  0, 0, 16'd16, 1'b1};
        vecs[3] = '{16, 1, 0, 16'd16, 1'b0};
        vecs[4] = '{5,  0, 1, 16'd5,  1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        do_reset();

        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_mem_own", 32'(mem_own), 32'd1);
        chk("rst_core_req", 32'(core_req), 32'd0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finished", 32'(finished), 32'd0);
        chk("rst_timed_out", 32'(timed_out), 32'd0);
        chk("rst_run_cycles", 32'(run_cycles), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_run(vecs[v].done_at, vecs[v].stall, vecs[v].mem_mode,
                   vecs[v].exp_cyc, vecs[v].exp_to, v * 37 + 3);
        end

        // Reset while the second preload word is on the bus.
        wr_q.delete();
        e.addr = 8'd0;
        e.data = 8'hA5;
        wr_q.push_back(e);
        start = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'hA5;
        tick();
        ld_data = 8'h5A;
        reset   = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_write", 32'(mem_wr_en), 32'd0);
        tick();
        chk("mid_rst_idle_busy", 32'(busy), 32'd0);
        chk("mid_rst_idle_finished", 32'(finished), 32'd0);
        chk("mid_rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("mid_rst_core_reset", 32'(core_reset), 32'd1);
        chk("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
        reset    = 1'b0;
        ld_valid = 1'b0;
        chk("mid_rst_word1_only", 32'(wr_q.size()), 32'd0);

        do_run(3, 1, 0, 16'd3, 1'b0, 200);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, tot_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_launcher.md
Name: prog_launcher

Overview:
- Host-side initiator for the processor's req/done run protocol; sits between the test/host environment and top_level.
- Per run: preloads a data-memory window from an input byte stream, holds the core in reset, then releases it with core_req.
- Waits for core_done with a timeout, then streams a result window of data memory back out.
- Owns the data-memory port whenever the core is not running.

Parameters:
- AW, 8, data-memory address width.
- DW, 8, data word width.
- LOAD_BASE, 0, first preload address.
- LOAD_LEN, 64, number of preload words (0 allowed).
- RES_BASE, 64, first result address.
- RES_LEN, 32, number of result words (0 allowed).
- TIMEOUT, 4096, maximum RUN cycles before abort.
- CW, 16, cycle-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a run when in IDLE or FINISH.
- ld_valid  in  1  preload stream valid.
- ld_data  in  DW  preload word.
- ld_ready  out  1  preload stream ready.
- core_reset  out  1  reset to the processor.
- core_req  out  1  run request to the processor.
- core_done  in  1  processor done.
- mem_own  out  1  1 = launcher drives the data-memory port; 0 = core drives it.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wr_data  out  DW  memory write data.
- mem_rd_data  in  DW  memory read data; combinational, same cycle as mem_addr.
- res_valid  out  1  result stream valid.
- res_data  out  DW  result word.
- res_ready  in  1  result stream ready.
- busy  out  1  high in any state other than IDLE and FINISH.
- finished  out  1  high in FINISH.
- timed_out  out  1  sticky abort flag, cleared by the next start.
- run_cycles  out  CW  RUN cycle count, saturating.
- checksum  out  DW  see Optional Feature.

Behaviour:
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> CORE_RST after LOAD_LEN accepted words.
  - CORE_RST -> RUN after 2 cycles.
  - RUN -> DRAIN on done; RUN -> FINISH on timeout.
  - DRAIN -> FINISH after RES_LEN transfers.
  - FINISH -> LOAD on start.
  - LOAD_LEN = 0: skip LOAD. RES_LEN = 0: skip DRAIN.
- Reset values:
  - State IDLE; core_reset = 1; mem_own = 1.
  - All other outputs 0: core_req, mem_wr_en, mem_addr, mem_wr_data, ld_ready, res_valid, res_data, busy, finished, timed_out, run_cycles, checksum.
- reset mid-operation: immediate return to IDLE; any in-flight transfer is dropped and no further write occurs.
- start is ignored in busy states. start in FINISH clears timed_out, run_cycles and checksum.
- LOAD:
  - ld_ready = 1.
  - Each ld_valid&&ld_ready cycle writes in the same cycle: mem_wr_en = 1, mem_addr = LOAD_BASE + index, mem_wr_data = ld_data.
  - Index increments per accepted word; address wraps modulo 2^AW.
  - No write when ld_valid = 0.
- CORE_RST: core_reset = 1 for exactly 2 cycles; core_done is ignored.
- RUN:
  - core_reset = 0, core_req = 1, mem_own = 0, mem_wr_en = 0.
  - run_cycles increments every RUN cycle and saturates at 2^CW-1.
  - core_done is sampled every cycle. First high -> DRAIN next cycle; the done cycle is counted.
  - If run_cycles reaches TIMEOUT with done low: set timed_out, go to FINISH, no drain.
  - Done and timeout in the same cycle: done wins.
- core_reset = 1 in all states except RUN.
- DRAIN:
  - mem_own = 1, mem_addr = RES_BASE + index, res_data = mem_rd_data (combinational), res_valid = 1.
  - Index advances on res_valid&&res_ready. res_data is stable while res_ready = 0.
- FINISH: finished = 1; run_cycles holds its final value.

Optional Feature:
- Macro LAUNCH_CHECKSUM_EN.
- Defined: checksum = running 8-bit XOR of every drained word (updated on each res handshake), reset to 0 on start.
- Undefined: checksum is tied to 0 and no accumulator logic is built.

Decomposition:
- Package launch_pkg:
  - State enum: IDLE, LOAD, CORE_RST, RUN, DRAIN, FINISH.
  - Constant CORE_RST_CYCLES = 2.
- Sub-module win_counter: load/increment/terminal-count index counter with base-address add. Instantiated twice (load, drain).
- FSM and run_cycles logic stay in prog_launcher.

Test Plan:
- Basic run: LOAD_LEN = 4; stream 0x11,0x22,0x33,0x44 with ld_valid held -> writes to addresses 0..3 on 4 consecutive cycles; core_reset high for 2 cycles; core_req rises.
- Completion: core_done asserted on 10th RUN cycle -> run_cycles = 10. With mem_rd_data modeled as an 8-bit memory preloaded at 64..95, 32 result words emitted in address order; finished = 1.
- Backpressure: res_ready toggles 1,0,0,1 -> res_data stable through stall cycles; no word skipped or duplicated.
- Timeout: TIMEOUT = 16, core_done never asserted -> timed_out = 1 after 16 RUN cycles, state FINISH, res_valid never high.
- Mid-run reset: assert reset during LOAD word 2 -> next cycle IDLE, mem_wr_en = 0, core_reset = 1; a later start reloads from LOAD_BASE.
- Checksum (macro defined): drained words 0x0F,0xF0,0xFF -> checksum = 0x00. Macro undefined -> checksum = 0 throughout.
